// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register with sequential increment and redirect path,
// feeding a FIFO fetch buffer that hands {pc, instr} pairs to decode over valid/ready.
module fetch_unit #(
  parameter int                  PC_WIDTH     = 64,
  parameter int                  INSTR_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  STRIDE       = 4,
  parameter int                  FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_target,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic [INSTR_WIDTH-1:0]        imem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [INSTR_WIDTH-1:0]        out_instr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          misalign_err
);

  localparam int                  PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                  CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(STRIDE);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(STRIDE - 1);

  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    buf_pc    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] buf_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   pop;
  logic                   push;
  logic                   target_misaligned;

  assign imem_addr         = pc;
  assign fifo_count        = count;
  assign out_valid         = (count != '0);
  assign pop               = out_valid & out_ready;
  // A full buffer may still accept a fetch when the head leaves in the same cycle.
  assign push              = !misalign_err && !redirect_valid && ((count < DEPTH_CNT) || pop);
  assign target_misaligned = ((redirect_target & ALIGN_MASK) != '0);
  assign out_pc            = out_valid ? buf_pc[rd_ptr]    : '0;
  assign out_instr         = out_valid ? buf_instr[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc           <= redirect_target;
      misalign_err <= target_misaligned;
    end else if (push) begin
      pc           <= pc + PC_STEP;
    end
  end

  // Redirect flushes by resetting both pointers; the head handshake of that cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= pc;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a queue-based fetch model predicts buffered
// entries, and an independent monitor checks every accepted head against that queue.
module tb_fetch_unit;

  localparam logic [31:0] SALT = 32'hC3C3_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fifo_count;
  logic        misalign_err;

  logic        redirect_valid8 = 1'b0;
  logic [7:0]  redirect_target8 = 8'h00;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_rdata8;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  out_pc8;
  logic [31:0] out_instr8;
  logic [2:0]  fifo_count8;
  logic        misalign_err8;

  int     compared = 0;
  int     mismatched = 0;
  int     step_no = 0;
  entry_t exp_q[$];
  logic [63:0] m_pc;
  bit     m_err;

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr[31:0] ^ SALT;
  assign imem_rdata8 = {24'h0, imem_addr8} ^ SALT;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .fifo_count(fifo_count), .misalign_err(misalign_err)
  );

  fetch_unit #(.PC_WIDTH(8), .RESET_VECTOR(8'hF8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid8), .redirect_target(redirect_target8),
    .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_pc(out_pc8), .out_instr(out_instr8),
    .fifo_count(fifo_count8), .misalign_err(misalign_err8)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (step %0d)", name, act, exp, step_no);
    end
  endtask

  // One cycle: drive at the negedge, check state, let the monitor pop, then advance the model.
  task automatic apply_stimulus(input bit rv, input logic [63:0] tgt, input bit rdy);
    bit m_pop;
    bit m_push;
    step_no++;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = rdy;
    #1;
    check_output("imem_addr", imem_addr, m_pc);
    check_output("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_output("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    check_output("misalign_err", 64'(misalign_err), 64'(m_err));
    if (step_no >= 2 && step_no <= 7) begin
      logic [7:0] e8;
      e8 = 8'hF8 + 8'(4 * (step_no - 2));
      check_output("pc8_wrap", 64'(out_pc8), 64'(e8));
      check_output("instr8_wrap", 64'(out_instr8), 64'({24'h0, e8} ^ SALT));
    end
    m_pop  = (exp_q.size() != 0) && rdy;
    m_push = !m_err && !rv && ((exp_q.size() < 4) || m_pop);
    #2;
    if (rv) begin
      exp_q.delete();
      m_pc  = tgt;
      m_err = (tgt[1:0] != 2'b00);
    end else if (m_push) begin
      exp_q.push_back('{pc: m_pc, instr: m_pc[31:0] ^ SALT});
      m_pc = m_pc + 64'd4;
    end
    @(negedge clk);
  endtask

  task automatic run_idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 64'h0, rdy);
  endtask

  // Monitor: every accepted head must match the oldest predicted entry.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_pop_pc", out_pc, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        check_output("head_pc", out_pc, exp_q[0].pc);
        check_output("head_instr", 64'(out_instr), 64'(exp_q[0].instr));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    out_ready = 1'b0;
    m_pc = 64'h0;
    m_err = 1'b0;
    #12;
    check_output("rst_out_valid", 64'(out_valid), 64'h0);
    check_output("rst_out_pc", out_pc, 64'h0);
    check_output("rst_out_instr", 64'(out_instr), 64'h0);
    check_output("rst_fifo_count", 64'(fifo_count), 64'h0);
    check_output("rst_imem_addr", imem_addr, 64'h0);
    check_output("rst_pc8", 64'(imem_addr8), 64'hF8);
    @(negedge clk);
    rst_n = 1'b1;

    run_idle(12, 1'b1);
    run_idle(10, 1'b0);
    run_idle(8, 1'b1);
    run_idle(6, 1'b0);
    run_idle(6, 1'b1);

    apply_stimulus(1'b1, 64'h40, 1'b1);
    run_idle(3, 1'b0);
    apply_stimulus(1'b1, 64'h100, 1'b0);
    run_idle(6, 1'b1);

    apply_stimulus(1'b1, 64'h102, 1'b1);
    run_idle(5, 1'b1);
    apply_stimulus(1'b1, 64'h301, 1'b1);
    apply_stimulus(1'b1, 64'h200, 1'b1);
    run_idle(6, 1'b1);

    apply_stimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    run_idle(3, 1'b0);
    run_idle(5, 1'b1);

    // Asynchronous reset between edges must clear outputs immediately.
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_out_valid", 64'(out_valid), 64'h0);
    check_output("async_out_pc", out_pc, 64'h0);
    check_output("async_fifo_count", 64'(fifo_count), 64'h0);
    check_output("async_imem_addr", imem_addr, 64'h0);
    check_output("async_out_valid8", 64'(out_valid8), 64'h0);
    exp_q.delete();
    m_pc  = 64'h0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_idle(6, 1'b1);

    for (int i = 0; i < 300; i++) begin
      bit          rv;
      logic [63:0] tgt;
      rv  = ($urandom_range(0, 11) == 0);
      tgt = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      apply_stimulus(rv, tgt, $urandom_range(0, 3) != 0);
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
